layer_three: RTL and testbench

- Final classifier stage. Sits directly downstream of the second conv/pool stage.
- Consumes its 196-bit binary feature map (4 filters x 7x7) and runs a binary fully-connected layer of 10 neurons (XNOR + popcount).
- Performs a sequential argmax and reports the predicted digit (0-9), its score, and all 10 raw scores to the top-level controller.

---
 rtl/layer_three_pkg.sv | 31 +++
 rtl/layer_three_popcount49.sv | 23 ++
 rtl/layer_three.sv | 113 +++++++++++
 tb/tb_layer_three.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/layer_three_pkg.sv
// Shared definitions for the classifier layers: top-level FSM encodings, layer geometry
// and the feature bit-index helper.
package layer_three_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_LOAD    = 3'b001,
        S_LAYER_1 = 3'b010,
        S_LAYER_2 = 3'b011,
        S_LAYER_3 = 3'b100,
        S_DONE    = 3'b101
    } state_t;

    typedef enum logic {
        PH_CALC,
        PH_FIN
    } phase_t;

    localparam int N_IN    = 196;
    localparam int N_OUT   = 10;
    localparam int CHUNK   = 49;
    localparam int N_CHUNK = N_IN / CHUNK;
    localparam int ROW_W   = 7;
    localparam int SCORE_W = 8;

    // Bit position of filter plane wn, row r, column c in the upstream feature map.
    function automatic int feat_idx(input int wn, input int r, input int c);
        return wn * CHUNK + r * ROW_W + c;
    endfunction

endpackage

// File: rtl/layer_three_popcount49.sv
// Combinational 49-bit popcount: seven 7-bit row counts summed into a 6-bit result.
// Zero latency, no flow control.
module layer_three_popcount49
    import layer_three_pkg::*;
(
    input  logic [CHUNK-1:0] bits,
    output logic [5:0]       count
);

    logic [2:0] grp [ROW_W];

    always_comb begin
        count = '0;
        for (int g = 0; g < ROW_W; g++) begin
            grp[g] = '0;
            for (int b = 0; b < ROW_W; b++) begin
                grp[g] = grp[g] + {2'b00, bits[g*ROW_W + b]};
            end
            count = count + {3'b000, grp[g]};
        end
    end

endmodule

// File: rtl/layer_three.sv
// Binary FC layer (10 neurons, XNOR+popcount) with sequential argmax; one 49-bit chunk per
// active cycle, results final after 40 active edges, sticky done on the 41st; state pauses.
module layer_three
    import layer_three_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 state,
    input  logic [N_IN-1:0]            features,
    input  logic [N_OUT*N_IN-1:0]      weights,
    output logic [3:0]                 class_out,
    output logic [SCORE_W-1:0]         max_score,
    output logic [N_OUT*SCORE_W-1:0]   scores,
    output logic                       done
);

    logic [3:0]                        neuron_q, neuron_d;
    logic [1:0]                        chunk_q, chunk_d;
    logic [SCORE_W-1:0]                acc_q, acc_d;
    logic [3:0]                        class_q, class_d;
    logic [SCORE_W-1:0]                max_q, max_d;
    logic [N_OUT-1:0][SCORE_W-1:0]     scores_q, scores_d;
    phase_t                            phase_q, phase_d;

    logic [N_IN-1:0]                   w_row;
    logic [CHUNK-1:0]                  f_chunk, w_chunk, match;
    logic [5:0]                        pc;
    logic [SCORE_W-1:0]                total;
    logic                              active;

    // Constant-index muxes keep the wide operand selection free of dynamic part-selects.
    always_comb begin
        w_row   = '0;
        f_chunk = '0;
        w_chunk = '0;
        for (int n = 0; n < N_OUT; n++) begin
            if (neuron_q == 4'(n)) w_row = weights[n*N_IN +: N_IN];
        end
        for (int c = 0; c < N_CHUNK; c++) begin
            if (chunk_q == 2'(c)) begin
                f_chunk = features[c*CHUNK +: CHUNK];
                w_chunk = w_row[c*CHUNK +: CHUNK];
            end
        end
        match = ~(f_chunk ^ w_chunk);
    end

    layer_three_popcount49 u_popcount (
        .bits  (match),
        .count (pc)
    );

    assign active = (state == S_LAYER_3);
    assign total  = acc_q + {2'b00, pc};

    always_comb begin
        neuron_d = neuron_q;
        chunk_d  = chunk_q;
        acc_d    = acc_q;
        class_d  = class_q;
        max_d    = max_q;
        scores_d = scores_q;
        phase_d  = phase_q;
        if (active) begin
            if (neuron_q < 4'(N_OUT)) begin
                if (chunk_q != 2'(N_CHUNK - 1)) begin
                    acc_d   = total;
                    chunk_d = chunk_q + 2'd1;
                end else begin
                    for (int n = 0; n < N_OUT; n++) begin
                        if (neuron_q == 4'(n)) scores_d[n] = total;
                    end
                    // Strict compare: a tie keeps the earlier (lower) neuron index.
                    if (neuron_q == 4'd0 || total > max_q) begin
                        max_d   = total;
                        class_d = neuron_q;
                    end
                    acc_d    = '0;
                    chunk_d  = '0;
                    neuron_d = neuron_q + 4'd1;
                end
            end else begin
                phase_d = PH_FIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neuron_q <= '0;
            chunk_q  <= '0;
            acc_q    <= '0;
            class_q  <= '0;
            max_q    <= '0;
            scores_q <= '0;
            phase_q  <= PH_CALC;
        end else begin
            neuron_q <= neuron_d;
            chunk_q  <= chunk_d;
            acc_q    <= acc_d;
            class_q  <= class_d;
            max_q    <= max_d;
            scores_q <= scores_d;
            phase_q  <= phase_d;
        end
    end

    assign class_out = class_q;
    assign max_score = max_q;
    assign scores    = scores_q;
    assign done      = (phase_q == PH_FIN);

endmodule

// File: tb/tb_layer_three.sv
// Self-checking bench for layer_three: directed/random vectors against a per-neuron match-count model.
module tb_layer_three;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     state = 3'b000;
    logic [195:0]   features = '0;
    logic [1959:0]  weights = '0;
    logic [3:0]     class_out;
    logic [7:0]     max_score;
    logic [79:0]    scores;
    logic           done;

    int errors = 0;
    int checks = 0;

    layer_three dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .features  (features),
        .weights   (weights),
        .class_out (class_out),
        .max_score (max_score),
        .scores    (scores),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [195:0]  f;
        logic [1959:0] w;
        logic [3:0]    cls;
        logic [7:0]    mx;
        logic [79:0]   sc;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: score = number of agreeing bits across the whole 196-bit vector.
    function automatic logic [79:0] model_scores(input logic [195:0] f, input logic [1959:0] w);
        logic [79:0] s;
        s = '0;
        for (int n = 0; n < 10; n++) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 196; i++) if (f[i] == w[n*196 + i]) cnt++;
            s[n*8 +: 8] = 8'(cnt);
        end
        return s;
    endfunction

    function automatic logic [3:0] model_class(input logic [79:0] s);
        int best;
        best = 0;
        for (int n = 1; n < 10; n++) if (s[n*8 +: 8] > s[best*8 +: 8]) best = n;
        return 4'(best);
    endfunction

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        edges(2);
        rst_n = 1'b1;
        edges(1);
    endtask

    task automatic run_vec(input int k);
        state = 3'b000;
        do_reset();
        features = vecs[k].f;
        weights  = vecs[k].w;
        state    = 3'b100;
        edges(40);
        check($sformatf("v%0d done_at_40", k), {79'b0, done}, 80'd0);
        check($sformatf("v%0d class", k), {76'b0, class_out}, {76'b0, vecs[k].cls});
        check($sformatf("v%0d max", k), {72'b0, max_score}, {72'b0, vecs[k].mx});
        check($sformatf("v%0d scores", k), scores, vecs[k].sc);
        edges(1);
        check($sformatf("v%0d done_at_41", k), {79'b0, done}, 80'd1);
    endtask

    initial begin
        logic [79:0]   sc;
        logic [1959:0] w;
        logic [195:0]  f;

        // v0: features zero, all-ones weights except neuron 3 all zeros
        w = '1;
        w[3*196 +: 196] = '0;
        sc = '0;
        sc[3*8 +: 8] = 8'd196;
        vecs[0] = '{f: '0, w: w, cls: 4'd3, mx: 8'd196, sc: sc};

        // v1: everything ones -> all 196, tie resolves to neuron 0
        sc = '0;
        for (int n = 0; n < 10; n++) sc[n*8 +: 8] = 8'd196;
        vecs[1] = '{f: '1, w: '1, cls: 4'd0, mx: 8'd196, sc: sc};

        // v2: neuron n has 10n+5 ones
        w = '0;
        sc = '0;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 10*n + 5; i++) w[n*196 + i] = 1'b1;
            sc[n*8 +: 8] = 8'(10*n + 5);
        end
        vecs[2] = '{f: '1, w: w, cls: 4'd9, mx: 8'd95, sc: sc};

        // v3: neurons 2 and 7 both match features exactly, others are the complement
        for (int i = 0; i < 196; i++) f[i] = 1'($urandom_range(0, 1));
        sc = '0;
        for (int n = 0; n < 10; n++) w[n*196 +: 196] = ~f;
        w[2*196 +: 196] = f;
        w[7*196 +: 196] = f;
        sc[2*8 +: 8] = 8'd196;
        sc[7*8 +: 8] = 8'd196;
        vecs[3] = '{f: f, w: w, cls: 4'd2, mx: 8'd196, sc: sc};

        // v4..v9: random, some with duplicated rows to create ties
        for (int k = 4; k < NVEC; k++) begin
            for (int i = 0; i < 196; i++) f[i] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 1960; i++) w[i] = 1'($urandom_range(0, 1));
            if (k % 2 == 0) begin
                w[1*196 +: 196] = f ^ 196'(1);
                w[6*196 +: 196] = w[1*196 +: 196];
            end
            sc = model_scores(f, w);
            vecs[k] = '{f: f, w: w, cls: model_class(sc), mx: sc[model_class(sc)*8 +: 8], sc: sc};
        end

        // Reset state
        rst_n = 1'b0;
        #2;
        check("reset_class", {76'b0, class_out}, 80'd0);
        check("reset_max", {72'b0, max_score}, 80'd0);
        check("reset_scores", scores, 80'd0);
        check("reset_done", {79'b0, done}, 80'd0);

        for (int k = 0; k < NVEC; k++) run_vec(k);

        // Done persistence: leave s_LAYER_3 for 20 cycles, then return
        state = 3'b000;
        edges(20);
        check("persist_done", {79'b0, done}, 80'd1);
        check("persist_class", {76'b0, class_out}, {76'b0, vecs[NVEC-1].cls});
        check("persist_scores", scores, vecs[NVEC-1].sc);
        state = 3'b100;
        edges(5);
        check("persist_active_scores", scores, vecs[NVEC-1].sc);
        check("persist_active_done", {79'b0, done}, 80'd1);

        // Pause after 13 active edges (neurons 0..2 finished)
        state = 3'b000;
        do_reset();
        features = vecs[2].f;
        weights  = vecs[2].w;
        state    = 3'b100;
        edges(13);
        state = 3'b011;
        edges(7);
        check("pause_class", {76'b0, class_out}, 80'd2);
        check("pause_max", {72'b0, max_score}, 80'd25);
        check("pause_scores", scores, {56'd0, 8'd25, 8'd15, 8'd5});
        state = 3'b100;
        edges(27);
        check("pause_done_at_40", {79'b0, done}, 80'd0);
        check("pause_scores_final", scores, vecs[2].sc);
        check("pause_class_final", {76'b0, class_out}, 80'd9);
        edges(1);
        check("pause_done_at_41", {79'b0, done}, 80'd1);

        // Asynchronous reset mid-run at active cycle 22
        state = 3'b000;
        do_reset();
        features = vecs[0].f;
        weights  = vecs[0].w;
        state    = 3'b100;
        edges(22);
        check("pre_arst_class", {76'b0, class_out}, 80'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_class", {76'b0, class_out}, 80'd0);
        check("arst_max", {72'b0, max_score}, 80'd0);
        check("arst_scores", scores, 80'd0);
        check("arst_done", {79'b0, done}, 80'd0);
        edges(1);
        #2;
        rst_n = 1'b1;
        edges(40);
        check("rerun_done_at_40", {79'b0, done}, 80'd0);
        check("rerun_class", {76'b0, class_out}, 80'd3);
        check("rerun_scores", scores, vecs[0].sc);
        edges(1);
        check("rerun_done_at_41", {79'b0, done}, 80'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
